rd_weight_loader: RTL and testbench

Runtime writer for the 256-entry × 24-bit rotation-dense weight table used by the MRELBP feature path. It replaces the fixed file-initialised ROM with a register-array table that is filled at run time from an 8-bit byte stream with valid/ready handshake. The table keeps an asynchronous read port with the same semantics as the ROM it replaces, so downstream feature logic indexes it unchanged. It sits between the host/UART byte receiver and the MRELBP dense-weight consumer.

---
 rtl/mrelbp_pkg.sv | 16 +
 rtl/rd_weight_loader_byte_packer.sv | 44 ++++
 rtl/rd_weight_loader.sv | 132 +++++++++++++
 tb/tb_rd_weight_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mrelbp_pkg.sv
// Shared definitions for the MRELBP rotation-dense weight path.
// Table geometry and the runtime loader state encoding.
package mrelbp_pkg;

    localparam int RD_DEPTH = 256;
    localparam int RD_AW    = 8;
    localparam int RD_DW    = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHK,
        ST_DONE
    } rd_state_t;

endpackage

// File: rtl/rd_weight_loader_byte_packer.sv
// Assembles DW/8 stream bytes, first byte in the MSBs, into one word.
// word_valid pulses in the cycle the completing byte is accepted.
module byte_packer #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    output logic          word_valid,
    output logic [DW-1:0] word
);

    localparam int NB = DW / 8;

    generate
        if (NB > 1) begin : g_multi
            localparam int CW = $clog2(NB);

            logic [CW-1:0]   cnt;
            logic [DW-9:0]   sh;
            logic            last;

            assign last       = (cnt == CW'(NB - 1));
            assign word       = {sh, in_byte};
            assign word_valid = in_valid && last;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt <= '0;
                    sh  <= '0;
                end else if (in_valid) begin
                    sh  <= word[DW-9:0];
                    cnt <= last ? '0 : cnt + CW'(1);
                end
            end
        end else begin : g_single
            assign word       = in_byte;
            assign word_valid = in_valid;
        end
    endgenerate

endmodule

// File: rtl/rd_weight_loader.sv
// Runtime loader for the rotation-dense weight table, async read port.
// Optional trailing checksum byte: define RD_LOADER_CHECKSUM_EN.
module rd_weight_loader
    import mrelbp_pkg::*;
#(
    parameter int DEPTH = RD_DEPTH,
    parameter int AW    = RD_AW,
    parameter int DW    = RD_DW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [7:0]    i_byte,
    input  logic          i_byte_valid,
    output logic          o_byte_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [AW:0]   o_wr_count,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    rd_state_t     state, state_nx;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   wr_count;
    logic          accept, load_acc, clr;
    logic          word_valid, last_entry;
    logic [DW-1:0] word;
    logic [DW-1:0] mem [DEPTH];

    assign accept     = i_byte_valid && o_byte_ready;
    assign load_acc   = accept && (state == ST_LOAD);
    assign clr        = i_start && (state == ST_IDLE || state == ST_DONE);
    assign last_entry = word_valid && (wr_addr == AW'(DEPTH - 1));

    byte_packer #(.DW(DW)) u_packer (
        .clk        (i_clk),
        .rst        (i_rst),
        .clr        (clr),
        .in_valid   (load_acc),
        .in_byte    (i_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_nx     = state;
        o_byte_ready = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_start) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
`ifdef RD_LOADER_CHECKSUM_EN
                if (last_entry) state_nx = ST_CHK;
`else
                if (last_entry) state_nx = ST_DONE;
`endif
            end
            ST_CHK: begin
`ifdef RD_LOADER_CHECKSUM_EN
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid) state_nx = ST_DONE;
`else
                state_nx = ST_IDLE;
`endif
            end
            ST_DONE: begin
                o_done = 1'b1;
                if (i_start) state_nx = ST_LOAD;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            wr_addr  <= '0;
            wr_count <= '0;
        end else begin
            state <= state_nx;
            if (clr) begin
                wr_addr  <= '0;
                wr_count <= '0;
            end else if (word_valid) begin
                wr_addr <= wr_addr + AW'(1);
                if (wr_count != (AW+1)'(DEPTH))
                    wr_count <= wr_count + (AW+1)'(1);
            end
        end
    end

    // Table is deliberately unreset; contents survive a mid-load abort.
    always_ff @(posedge i_clk) begin
        if (word_valid) mem[wr_addr] <= word;
    end

    assign o_rd_data  = mem[i_rd_addr];
    assign o_wr_count = wr_count;

`ifdef RD_LOADER_CHECKSUM_EN
    logic [7:0] sum, sum_nx;
    logic       err;

    assign sum_nx = sum + i_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum <= '0;
            err <= 1'b0;
        end else if (clr) begin
            sum <= '0;
            err <= 1'b0;
        end else begin
            if (load_acc) sum <= sum_nx;
            if (accept && state == ST_CHK && sum_nx != 8'h00) err <= 1'b1;
        end
    end

    assign o_err = err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_rd_weight_loader.sv
// Randomized self-checking bench for rd_weight_loader.
// Reference is a word-level table image updated per completed entry.
module tb_rd_weight_loader;
    import mrelbp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_d;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy, done, err;
    logic [8:0]  wr_count;
    logic [7:0]  rd_addr;
    logic [23:0] rd_data;

    int n_chk  = 0;
    int n_pass = 0;

    logic [23:0] words   [256];
    logic [23:0] exp_mem [256];

    always #5 clk = ~clk;

    rd_weight_loader dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_byte       (byte_d),
        .i_byte_valid (byte_valid),
        .o_byte_ready (byte_ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_wr_count   (wr_count),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle for random cycles, then present b until accepted (bounded).
    task automatic send_byte(input logic [7:0] b, input int duty,
                             inout bit flags_ok, output bit ok);
        ok = 1'b0;
        while ($urandom_range(99) >= duty) begin
            byte_valid = 1'b0;
            if (byte_ready !== 1'b1 || done !== 1'b0) flags_ok = 1'b0;
            tick();
        end
        byte_valid = 1'b1;
        byte_d     = b;
        for (int t = 0; t < 16; t++) begin
            if (byte_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            flags_ok = 1'b0;
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic make_pattern();
        for (int k = 0; k < 256; k++) begin
            logic [7:0] kb;
            kb = k[7:0];
            words[k] = {kb, ~kb, 8'h5A};
        end
    endtask

    task automatic make_random();
        for (int k = 0; k < 256; k++) words[k] = 24'($urandom);
    endtask

    task automatic verify_table(input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            rd_addr = a[7:0];
            #1;
            if (rd_data !== exp_mem[a]) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Start a load and stream nbytes of words[]; optional mid-load start
    // and a read-during-write probe on entry probe (-1 disables).
    task automatic run_load(input string tag, input int nbytes,
                            input int duty, input int midstart,
                            input int probe, input int chk_delta);
        bit         flags_ok, ok;
        logic [7:0] b, sum;
        flags_ok = 1'b1;
        sum      = 8'h00;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_ready"}, byte_ready, 1);
        check({tag, "_start_done"}, done, 0);
        check({tag, "_start_cnt"}, wr_count, 0);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'(words[i/3] >> (8 * (2 - i % 3)));
            if (i == midstart) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check({tag, "_mid_busy"}, busy, 1);
                check({tag, "_mid_cnt"}, wr_count, i / 3);
            end
            if (probe >= 0 && i == probe * 3 + 2) begin
                rd_addr = probe[7:0];
                #1;
                check({tag, "_rdw_old"}, rd_data, exp_mem[probe]);
            end
            send_byte(b, duty, flags_ok, ok);
            if (!ok) begin
                check({tag, "_accept_timeout"}, 0, 1);
                return;
            end
            sum += b;
            if (i % 3 == 2) exp_mem[i/3] = words[i/3];
            if (probe >= 0 && i == probe * 3 + 2)
                check({tag, "_rdw_new"}, rd_data, words[probe]);
            if (i != nbytes - 1 && (byte_ready !== 1'b1 || done !== 1'b0))
                flags_ok = 1'b0;
        end
        if (nbytes == 768) begin
`ifdef RD_LOADER_CHECKSUM_EN
            check({tag, "_chk_done_early"}, done, 0);
            send_byte(8'(-sum + 8'(chk_delta)), 100, flags_ok, ok);
            if (!ok) check({tag, "_chk_timeout"}, 0, 1);
            check({tag, "_err"}, err, (chk_delta != 0) ? 1 : 0);
`else
            check({tag, "_err"}, err, 0);
`endif
            check({tag, "_done"}, done, 1);
            check({tag, "_busy"}, busy, 0);
            check({tag, "_ready"}, byte_ready, 0);
            check({tag, "_cnt"}, wr_count, 256);
        end
        check({tag, "_flags"}, flags_ok, 1);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_d     = 8'h00;
        byte_valid = 1'b0;
        rd_addr    = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_ready", byte_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cnt", wr_count, 0);

        make_pattern();
        run_load("pat", 768, 100, -1, -1, 0);
        rd_addr = 8'h03;
        #1;
        check("pat_rd03", rd_data, 24'h03FC5A);
        rd_addr = 8'hFF;
        #1;
        check("pat_rdff", rd_data, 24'hFF005A);
        verify_table("pat_table");
        repeat (5) tick();
        check("pat_done_hold", done, 1);

        make_random();
        run_load("duty30", 768, 30, -1, 10, 0);
        verify_table("duty30_table");

        make_random();
        run_load("abort", 100, 60, -1, -1, 0);
        check("abort_cnt", wr_count, 33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rst_done", done, 0);
        check("abort_rst_busy", busy, 0);
        check("abort_rst_cnt", wr_count, 0);
        verify_table("abort_kept");
        run_load("reload", 768, 70, -1, 40, 0);
        verify_table("reload_table");

        make_random();
        run_load("midstart", 768, 80, 300, -1, 0);
        verify_table("midstart_table");

`ifdef RD_LOADER_CHECKSUM_EN
        make_random();
        run_load("cksum_bad", 768, 90, -1, -1, 1);
        verify_table("cksum_bad_table");
        make_random();
        run_load("cksum_ok", 768, 90, -1, -1, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
